// File: rtl/sap_control_sequencer.sv
// SAP-1 controller/sequencer: six-state one-hot ring (T1..T6) clocked on the falling edge,
// decoding the IR opcode into the 12-bit control word and halting the machine on HLT.
module sap_control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       halted,
    output logic       cp,
    output logic       ep,
    output logic       lm_n,
    output logic       ce_n,
    output logic       li_n,
    output logic       ei_n,
    output logic       la_n,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb_n,
    output logic       lo_n
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic [5:0] t_state_q, t_state_d;
    logic       halted_q, halted_d;
    logic       ring_ok;

    assign ring_ok = (t_state_q != 6'd0) && ((t_state_q & (t_state_q - 6'd1)) == 6'd0);

    // HLT freezes the ring in T4 instead of advancing; a corrupted ring recovers to T1.
    always_comb begin
        t_state_d = t_state_q;
        halted_d  = halted_q;
        if (!ring_ok) begin
            t_state_d = T1;
        end else if (run && !halted_q) begin
            if (t_state_q == T4 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                t_state_d = {t_state_q[4:0], t_state_q[5]};
            end
        end
        if (!rst) begin
            t_state_d = T1;
            halted_d  = 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        t_state_q <= t_state_d;
        halted_q  <= halted_d;
    end

    // Control word: held inactive while reset is asserted or the machine is halted.
    always_comb begin
        cp   = 1'b0;
        ep   = 1'b0;
        lm_n = 1'b1;
        ce_n = 1'b1;
        li_n = 1'b1;
        ei_n = 1'b1;
        la_n = 1'b1;
        ea   = 1'b0;
        su   = 1'b0;
        eu   = 1'b0;
        lb_n = 1'b1;
        lo_n = 1'b1;
        if (rst && !halted_q) begin
            case (t_state_q)
                T1: begin
                    ep   = 1'b1;
                    lm_n = 1'b0;
                end
                T2: cp = 1'b1;
                T3: begin
                    ce_n = 1'b0;
                    li_n = 1'b0;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        lm_n = 1'b0;
                        ei_n = 1'b0;
                    end else if (opcode == OP_OUT) begin
                        ea   = 1'b1;
                        lo_n = 1'b0;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ce_n = 1'b0;
                        la_n = 1'b0;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ce_n = 1'b0;
                        lb_n = 1'b0;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        eu   = 1'b1;
                        la_n = 1'b0;
                        su   = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state = t_state_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: a vector table for the instruction mix plus
// hand-written sequences for halt, single-step and mid-instruction reset.
module tb_sap_control_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       halted;
    logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
    logic [11:0] cw;

    int checks   = 0;
    int failures = 0;

    // Control word packing: {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n}
    localparam logic [11:0] CW_IDLE   = 12'h3E3;
    localparam logic [11:0] CW_T1     = 12'h5E3;
    localparam logic [11:0] CW_T2     = 12'hBE3;
    localparam logic [11:0] CW_T3     = 12'h263;
    localparam logic [11:0] CW_ADR    = 12'h1A3;
    localparam logic [11:0] CW_LDA_T5 = 12'h2C3;
    localparam logic [11:0] CW_ALU_T5 = 12'h2E1;
    localparam logic [11:0] CW_ADD_T6 = 12'h3C7;
    localparam logic [11:0] CW_SUB_T6 = 12'h3CF;
    localparam logic [11:0] CW_OUT_T4 = 12'h3F2;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  op;
        logic [5:0]  exp_t;
        logic        exp_h;
        logic [11:0] exp_cw;
    } vec_t;

    vec_t vecs[$];

    sap_control_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .opcode  (opcode),
        .t_state (t_state),
        .halted  (halted),
        .cp      (cp),
        .ep      (ep),
        .lm_n    (lm_n),
        .ce_n    (ce_n),
        .li_n    (li_n),
        .ei_n    (ei_n),
        .la_n    (la_n),
        .ea      (ea),
        .su      (su),
        .eu      (eu),
        .lb_n    (lb_n),
        .lo_n    (lo_n)
    );

    assign cw = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n};

    // clock/reset block
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Advance past one active (falling) edge and settle before touching inputs/outputs.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] et, input logic eh, input logic [11:0] ecw);
        #1;
        checks++;
        if (t_state !== et) begin
            failures++;
            $display("FAIL %s t_state got=%b exp=%b", name, t_state, et);
        end
        checks++;
        if (halted !== eh) begin
            failures++;
            $display("FAIL %s halted got=%b exp=%b", name, halted, eh);
        end
        checks++;
        if (cw !== ecw) begin
            failures++;
            $display("FAIL %s ctrl got=%h exp=%h", name, cw, ecw);
        end
    endtask

    task automatic add_vec(input logic r, input logic rn, input logic [3:0] op,
                           input logic [5:0] t, input logic h, input logic [11:0] c);
        vec_t v;
        v.rst = r; v.run = rn; v.op = op; v.exp_t = t; v.exp_h = h; v.exp_cw = c;
        vecs.push_back(v);
    endtask

    // One full instruction: fetch opcode during T1..T3, execute opcode during T4..T6.
    task automatic add_instr(input logic [3:0] op_fetch, input logic [3:0] op_exec,
                             input logic [11:0] c4, input logic [11:0] c5, input logic [11:0] c6);
        add_vec(1'b1, 1'b1, op_fetch, S1, 1'b0, CW_T1);
        add_vec(1'b1, 1'b1, op_fetch, S2, 1'b0, CW_T2);
        add_vec(1'b1, 1'b1, op_fetch, S3, 1'b0, CW_T3);
        add_vec(1'b1, 1'b1, op_exec,  S4, 1'b0, c4);
        add_vec(1'b1, 1'b1, op_exec,  S5, 1'b0, c5);
        add_vec(1'b1, 1'b1, op_exec,  S6, 1'b0, c6);
    endtask

    initial begin
        rst    = 1'b0;
        run    = 1'b1;
        opcode = 4'h0;
        tick();
        tick();

        add_vec(1'b0, 1'b1, 4'h0, S1, 1'b0, CW_IDLE);
        add_instr(4'h0, 4'h0, CW_ADR,    CW_LDA_T5, CW_IDLE);
        add_instr(4'h1, 4'h1, CW_ADR,    CW_ALU_T5, CW_ADD_T6);
        add_instr(4'h2, 4'h2, CW_ADR,    CW_ALU_T5, CW_SUB_T6);
        add_instr(4'hE, 4'hE, CW_OUT_T4, CW_IDLE,   CW_IDLE);
        // Fetch with HLT on the bus must not matter; opcode 7 executes as a nop.
        add_instr(4'hF, 4'h7, CW_IDLE,   CW_IDLE,   CW_IDLE);
        add_vec(1'b1, 1'b0, 4'h7, S1, 1'b0, CW_T1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst    = vecs[i].rst;
            run    = vecs[i].run;
            opcode = vecs[i].op;
            check($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_h, vecs[i].exp_cw);
            tick();
        end

        // HLT: run to T4, halt on the edge ending T4, stay frozen for 10 cycles.
        run = 1'b1;
        opcode = 4'hF;
        check("hlt_t1", S1, 1'b0, CW_T1);
        tick(); tick(); tick();
        check("hlt_t4", S4, 1'b0, CW_IDLE);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("halt_hold%0d", i), S4, 1'b1, CW_IDLE);
        end
        rst = 1'b0;
        check("halt_rst_low", S4, 1'b1, CW_IDLE);
        tick();
        check("halt_rst_edge", S1, 1'b0, CW_IDLE);
        rst = 1'b1;
        opcode = 4'h0;
        check("halt_recover", S1, 1'b0, CW_T1);

        // Single-step: hold in T3 for 5 cycles, then continue to T4.
        tick(); tick();
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("step_hold%0d", i), S3, 1'b0, CW_T3);
        end
        run = 1'b1;
        tick();
        check("step_resume", S4, 1'b0, CW_ADR);

        // Reset in T5 of ADD abandons the instruction.
        opcode = 4'h1;
        tick();
        check("add_t5", S5, 1'b0, CW_ALU_T5);
        rst = 1'b0;
        check("add_t5_rst", S5, 1'b0, CW_IDLE);
        tick();
        check("add_rst_t1", S1, 1'b0, CW_IDLE);
        rst = 1'b1;
        check("add_rst_rel", S1, 1'b0, CW_T1);
        tick();
        check("add_rst_t2", S2, 1'b0, CW_T2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
